// File: rtl/pipe_stall_ctrl.sv
// Hazard sequencer for the 3-stage pipeline: turns load-use, redirect and memory-stall
// requests into PC/pipeline write enables, bubble and kill controls. Define PIPE_PERF_CNT_EN for counters.
module pipe_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             redirect,
    input  logic             mem_stall,
    output logic             pc_we,
    output logic             fx_we,
    output logic             xw_we,
    output logic             x_bubble,
    output logic             f_kill,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_HOLD = 2'd1,
        FLUSH   = 2'd2,
        FREEZE  = 2'd3
    } state_t;

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nx, saved_state, saved_state_nx, eff_state;
    logic [2:0] remaining, remaining_nx, saved_rem, saved_rem_nx, eff_rem;
    logic       held_redirect, held_redirect_nx, held_load_use, held_load_use_nx;
    logic       in_freeze, eff_redirect, eff_load_use, flush_accept;
    logic       pc_we_c, fx_we_c, xw_we_c, x_bubble_c, f_kill_c;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx         = state;
        saved_state_nx   = saved_state;
        remaining_nx     = remaining;
        saved_rem_nx     = saved_rem;
        held_redirect_nx = held_redirect;
        held_load_use_nx = held_load_use;
        pc_we_c          = 1'b1;
        fx_we_c          = 1'b1;
        xw_we_c          = 1'b1;
        x_bubble_c       = 1'b0;
        f_kill_c         = 1'b0;
        flush_accept     = 1'b0;

        // Leaving FREEZE, held events act as live inputs; with none pending, the saved state resumes.
        in_freeze    = (state == FREEZE);
        eff_redirect = redirect | (in_freeze & held_redirect);
        eff_load_use = load_use | (in_freeze & held_load_use);
        eff_state    = state;
        eff_rem      = remaining;
        if (in_freeze) begin
            eff_rem   = saved_rem;
            eff_state = (eff_redirect || eff_load_use) ? RUN : saved_state;
        end

        if (mem_stall) begin
            pc_we_c  = 1'b0;
            fx_we_c  = 1'b0;
            xw_we_c  = 1'b0;
            state_nx = FREEZE;
            if (!in_freeze) begin
                saved_state_nx = state;
                saved_rem_nx   = remaining;
            end
            if (redirect) begin
                held_redirect_nx = 1'b1;
                held_load_use_nx = 1'b0;
            end else if (load_use && !held_redirect) begin
                held_load_use_nx = 1'b1;
            end
        end else begin
            held_redirect_nx = 1'b0;
            held_load_use_nx = 1'b0;
            if (eff_redirect) begin
                f_kill_c     = 1'b1;
                flush_accept = 1'b1;
                remaining_nx = RELOAD;
                state_nx     = (RELOAD != 3'd0) ? FLUSH : RUN;
            end else if (eff_state == FLUSH) begin
                f_kill_c     = 1'b1;
                remaining_nx = eff_rem - 3'd1;
                state_nx     = (eff_rem == 3'd1) ? RUN : FLUSH;
            end else if (eff_load_use && eff_state == RUN) begin
                pc_we_c    = 1'b0;
                fx_we_c    = 1'b0;
                x_bubble_c = 1'b1;
                state_nx   = LU_HOLD;
            end else begin
                state_nx = RUN;
            end
        end
    end

    // Reset forces every control low immediately, not just at the next edge.
    assign pc_we      = rst_n & pc_we_c;
    assign fx_we      = rst_n & fx_we_c;
    assign xw_we      = rst_n & xw_we_c;
    assign x_bubble   = rst_n & x_bubble_c;
    assign f_kill     = rst_n & f_kill_c;
    assign ctrl_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (!rst_n) begin
            state         <= RUN;
            saved_state   <= RUN;
            remaining     <= 3'd0;
            saved_rem     <= 3'd0;
            held_redirect <= 1'b0;
            held_load_use <= 1'b0;
        end else begin
            state         <= state_nx;
            saved_state   <= saved_state_nx;
            remaining     <= remaining_nx;
            saved_rem     <= saved_rem_nx;
            held_redirect <= held_redirect_nx;
            held_load_use <= held_load_use_nx;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_we && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (flush_accept && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_flush_accept;
    assign unused_flush_accept = flush_accept;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Consumer end of the hazard-control interface in the 3-stage RISC-V pipeline (Fetch / Execute / Write).
- Takes hazard requests (load-use stall, branch/jump redirect, memory not-ready) and sequences them into PC and pipeline-register write enables, noop-bubble and squash controls.
- Owns a small FSM so that multi-cycle flushes and memory freezes are applied exactly once, and requests arriving during a freeze are held, not lost.
- Optional saturating performance counters.

Parameters:
- FLUSH_CYCLES, 1, number of cycles f_kill is asserted per redirect (1..7).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  reset, asynchronous, active-low.
- load_use  input  1  X-stage instruction sources the load result now in W.
- redirect  input  1  branch taken or jump in X; PC mux selects target this cycle.
- mem_stall  input  1  instruction or data memory not ready.
- pc_we  output  1  PC register write enable.
- fx_we  output  1  Fetch->Execute pipeline register write enable.
- xw_we  output  1  Execute->Write pipeline register write enable.
- x_bubble  output  1  force noop (addi x0,x0,0) into X->W register instead of X result.
- f_kill  output  1  replace the instruction being latched into F->X with a noop.
- ctrl_state  output  2  FSM state, debug (RUN=0, LU_HOLD=1, FLUSH=2, FREEZE=3).
- stall_cnt  output  CNT_W  cycles with pc_we=0.
- flush_cnt  output  CNT_W  redirect events accepted.

Behaviour:
- Reset (rst_n low, async): state=RUN, flush counter=0, held-event regs=0, stall_cnt=flush_cnt=0. Outputs during reset: pc_we=fx_we=xw_we=0, x_bubble=0, f_kill=0.
- Outputs are combinational from state, held-event regs and current inputs. State and counters update on posedge clk.
- Priority, highest first: mem_stall > redirect > load_use.
- RUN, no request: pc_we=fx_we=xw_we=1, x_bubble=f_kill=0.
- RUN, redirect (no mem_stall):
  - pc_we=fx_we=xw_we=1, f_kill=1; flush_cnt+1.
  - Next state: FLUSH with remaining=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - load_use in the same cycle is ignored.
- RUN, load_use only:
  - pc_we=0, fx_we=0, xw_we=1, x_bubble=1 (one-cycle bubble).
  - Next state: LU_HOLD.
- LU_HOLD: load_use is masked (no double stall); otherwise identical to RUN, including redirect handling. Returns to RUN after 1 cycle.
- FLUSH: pc_we=fx_we=xw_we=1, f_kill=1; remaining decrements; goes to RUN when remaining reaches 0.
  - A new redirect in FLUSH reloads remaining=FLUSH_CYCLES-1 and increments flush_cnt.
  - load_use is ignored in FLUSH.
- mem_stall in any state:
  - pc_we=fx_we=xw_we=0, x_bubble=f_kill=0.
  - Current state and remaining are saved; next state FREEZE.
  - Any redirect/load_use seen while stalled is latched into held-event regs; redirect overwrites load_use.
- FREEZE: same outputs while mem_stall=1. On the first cycle with mem_stall=0:
  - Held redirect (or a redirect input this cycle) is processed as if in RUN.
  - Else held or current load_use is processed as if in RUN.
  - Else resume the saved state with its saved remaining count.
  - Held-event regs clear when consumed.
- Async reset mid-stall or mid-flush discards all held events immediately.
- Counters saturate at all-ones; no wrap. stall_cnt increments on every post-reset cycle with pc_we=0.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cnt/flush_cnt registers implemented as above.
- Undefined: no counter flops; stall_cnt and flush_cnt tied to 0. All control behaviour identical.

Test Plan:
- Reset release, no requests, 5 cycles -> pc_we=fx_we=xw_we=1 every cycle; ctrl_state=0; stall_cnt=0.
- load_use held high 3 cycles -> cycle1: pc_we=0, x_bubble=1; cycle2: LU_HOLD, pc_we=1 (masked); cycle3: bubble again; stall_cnt=2.
- FLUSH_CYCLES=3, redirect 1 cycle -> f_kill=1 for 3 consecutive cycles, ctrl_state 0->2->2->0; flush_cnt=1. Second redirect in cycle 2 extends f_kill to cycle 4; flush_cnt=2.
- mem_stall 4 cycles with redirect pulsed in stall cycle 2 -> all enables 0 for 4 cycles; first cycle after: f_kill=1, pc_we=1; flush_cnt=1; stall_cnt=4.
- redirect and load_use same cycle -> f_kill=1, x_bubble=0, pc_we=1; no LU_HOLD entry.
- rst_n dropped mid-FREEZE holding a load_use -> outputs to reset values immediately; after release, RUN with no bubble.
